qpu_sequencer: RTL and testbench
================================

QPU_SEQUENCER -- requirements
Module: qpu_sequencer

Interface
REQ-001 Parameter PC_W, default 4, program-counter width; program length is 2^PC_W.
REQ-002 Parameter SETTLE, default 2, wait cycles between the last gate acceptance and the measurement sample (range 1..15).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that launches a program run from address 0.
REQ-006 abort  input  1  level; terminates any run.
REQ-007 pc  output  PC_W  program ROM address.
REQ-008 instr  input  7  combinational ROM data for the current pc.
REQ-009 issue_valid  output  1  gate command valid toward the quantum core.
REQ-010 opcode/qubit1/qubit2  output  3/2/2  registered gate fields: instr[6:4], instr[3:2], instr[1:0].
REQ-011 core_ready  input  1  core accepts the gate when high with issue_valid on the same edge.
REQ-012 meas_result  input  2  combinational measurement of the current core state.
REQ-013 meas_valid  output  1  one-cycle strobe: meas_data was updated.
REQ-014 meas_data  output  2  last captured measurement.
REQ-015 busy  output  1  high in every state except IDLE and DONE.
REQ-016 done  output  1  one-cycle pulse on entry to DONE.
REQ-017 gate_count  output  PC_W+1  number of gates accepted in the current run.

Function
REQ-018 States: IDLE, FETCH, ISSUE, SETTLE_W, MEAS, DONE.
REQ-019 IDLE: on start go to FETCH, pc=0, gate_count=0; all other inputs are ignored.
REQ-020 FETCH (1 cycle): register instr fields; opcode 3'b111 = HALT -> DONE; opcode 3'b110 = MEAS -> SETTLE_W; otherwise -> ISSUE.
REQ-021 ISSUE: issue_valid=1 with fields held stable; leave only on an edge with core_ready=1; then gate_count+1 and advance pc.
REQ-022 Advance pc: if pc < 2^PC_W-1, pc+1 -> FETCH; if pc = 2^PC_W-1, pc wraps to 0 -> DONE (end of program, no re-execution).
REQ-023 MEAS and HALT are never presented on issue_valid and do not increment gate_count.
REQ-024 SETTLE_W: counter loaded with SETTLE-1 on entry, decrements to 0, then -> MEAS; SETTLE=1 gives a single cycle in SETTLE_W.
REQ-025 MEAS (1 cycle): meas_data <= meas_result, meas_valid=1 for that cycle, advance pc per REQ-022.
REQ-026 DONE (1 cycle): done=1 -> IDLE; pc, gate_count and meas_data are held until the next start.
REQ-027 abort high in any non-IDLE state: next state IDLE, issue_valid=0 from the next cycle; no done pulse; counters hold. abort has priority over start and core_ready on the same edge; a gate with core_ready=1 on the abort edge is counted but pc is not advanced.
REQ-028 start while busy is ignored.
REQ-029 gate_count saturates at 2^PC_W and does not wrap.

Reset
REQ-030 reset_n low asynchronously forces IDLE; pc=0, opcode=0, qubit1=0, qubit2=0, issue_valid=0, meas_valid=0, meas_data=0, done=0, busy=0, gate_count=0, settle counter=0.
REQ-031 Reset asserted mid-run discards the run; there is no pending output after release.

Structure
REQ-032 A shared package holds the state enumeration, the opcode constants OP_HALT=3'b111 and OP_MEAS=3'b110, and the instruction field bit positions; the quantum core decode uses the same package.
REQ-033 Sub-module settle_timer (load, count, zero flag) is the single permitted child; the FSM and pc/count logic stay flat.

Verification
REQ-034 3 gates + HALT at pc 3, core_ready tied 1: issue_valid pulses at pc 0,1,2; done follows 1 cycle after FETCH of pc 3; gate_count=3.
REQ-035 core_ready low for 4 cycles on gate at pc 0: issue_valid and fields stay constant for 5 cycles; pc stays 0; then advances to 1.
REQ-036 MEAS at pc 1, SETTLE=2, meas_result=2'b10: meas_valid one cycle exactly 3 cycles after FETCH of pc 1 (2 settle + 1 capture); meas_data=2'b10; no issue_valid for pc 1.
REQ-037 16 non-halt gates, core_ready=1: pc wraps 15->0, done pulses once, gate_count=16, busy falls.
REQ-038 abort during ISSUE with core_ready=1 at pc 5: IDLE next cycle, pc=5, gate_count includes that gate, no done; a subsequent start restarts at pc 0 with gate_count 0.
REQ-039 reset_n pulsed low asynchronously (between clock edges) mid-SETTLE_W: all outputs reach reset values immediately; no meas_valid after release.

Source files
------------

// File: rtl/qpu_sequencer_pkg.sv
// Shared definitions for the QPU sequencer and the quantum core decode:
// FSM states, reserved opcodes and instruction field positions.
package qpu_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_SETTLE_W,
        ST_MEAS,
        ST_DONE
    } state_t;

    localparam int INSTR_W = 7;

    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [2:0] OP_MEAS = 3'b110;

    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 4;
    localparam int Q1_MSB  = 3;
    localparam int Q1_LSB  = 2;
    localparam int Q2_MSB  = 1;
    localparam int Q2_LSB  = 0;

    function automatic logic [2:0] instrOpcode(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [1:0] instrQubit1(input logic [INSTR_W-1:0] instr);
        return instr[Q1_MSB:Q1_LSB];
    endfunction

    function automatic logic [1:0] instrQubit2(input logic [INSTR_W-1:0] instr);
        return instr[Q2_MSB:Q2_LSB];
    endfunction

endpackage

// File: rtl/qpu_sequencer_if.sv
// Gate-issue and measurement link between the sequencer (master) and the
// quantum core (slave).
interface qpu_sequencer_if;

    logic       issue_valid;
    logic [2:0] opcode;
    logic [1:0] qubit1;
    logic [1:0] qubit2;
    logic       core_ready;
    logic [1:0] meas_result;

    modport master (
        output issue_valid,
        output opcode,
        output qubit1,
        output qubit2,
        input  core_ready,
        input  meas_result
    );

    modport slave (
        input  issue_valid,
        input  opcode,
        input  qubit1,
        input  qubit2,
        output core_ready,
        output meas_result
    );

endinterface

// File: rtl/qpu_sequencer_settle_timer.sv
// Down-counter that times the settle gap before a measurement sample;
// o_zero flags that the wait has elapsed.
module settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_loadValue,
    input  logic         i_count,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    // Load wins over count so a fresh measurement always restarts the wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_count && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/qpu_sequencer.sv
// Program sequencer: fetches 7-bit instructions from a ROM, issues gates to
// the quantum core with a valid/ready handshake and samples measurements.
module qpu_sequencer
    import qpu_sequencer_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [PC_W-1:0]      pc,
    input  logic [INSTR_W-1:0]   instr,
    qpu_sequencer_if.master      core,
    output logic                 meas_valid,
    output logic [1:0]           meas_data,
    output logic                 busy,
    output logic                 done,
    output logic [PC_W:0]        gate_count
);

    localparam logic [PC_W-1:0] PC_LAST     = '1;
    localparam logic [PC_W:0]   COUNT_MAX   = {1'b1, {PC_W{1'b0}}};
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);

    state_t          r_state;
    state_t          w_nextState;
    logic [PC_W-1:0] r_pc;
    logic [2:0]      r_opcode;
    logic [1:0]      r_qubit1;
    logic [1:0]      r_qubit2;
    logic [1:0]      r_measData;
    logic [PC_W:0]   r_gateCount;

    logic       w_abortRun;
    logic       w_pcLast;
    logic [2:0] w_fetchOp;
    logic       w_accept;
    logic       w_advance;
    logic       w_measCapture;
    logic       w_timerLoad;
    logic       w_timerCount;
    logic       w_timerZero;
    logic       w_issueValid;
    logic       w_measValid;
    logic       w_done;
    logic       w_busy;

    assign w_abortRun = abort && (r_state != ST_IDLE);
    assign w_pcLast   = (r_pc == PC_LAST);
    assign w_fetchOp  = instrOpcode(instr);

    settle_timer #(
        .W (4)
    ) u_settleTimer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_timerLoad),
        .i_loadValue (SETTLE_LOAD),
        .i_count     (w_timerCount),
        .o_zero      (w_timerZero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_issueValid  = 1'b0;
        w_measValid   = 1'b0;
        w_done        = 1'b0;
        w_busy        = 1'b1;
        w_accept      = 1'b0;
        w_advance     = 1'b0;
        w_measCapture = 1'b0;
        w_timerLoad   = 1'b0;
        w_timerCount  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_fetchOp == OP_HALT) begin
                    w_nextState = ST_DONE;
                end else if (w_fetchOp == OP_MEAS) begin
                    w_nextState = ST_SETTLE_W;
                    w_timerLoad = 1'b1;
                end else begin
                    w_nextState = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issueValid = 1'b1;
                if (core.core_ready) begin
                    w_accept    = 1'b1;
                    w_advance   = 1'b1;
                    w_nextState = w_pcLast ? ST_DONE : ST_FETCH;
                end
            end
            // The sample is taken on the edge into MEAS so that meas_data is
            // already valid during the cycle meas_valid is high.
            ST_SETTLE_W: begin
                if (w_timerZero) begin
                    w_measCapture = 1'b1;
                    w_nextState   = ST_MEAS;
                end else begin
                    w_timerCount = 1'b1;
                end
            end
            ST_MEAS: begin
                w_measValid = 1'b1;
                w_advance   = 1'b1;
                w_nextState = w_pcLast ? ST_DONE : ST_FETCH;
            end
            ST_DONE: begin
                w_busy      = 1'b0;
                w_done      = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        // An accepted gate on the abort edge still counts; nothing else moves.
        if (w_abortRun) begin
            w_nextState   = ST_IDLE;
            w_advance     = 1'b0;
            w_measCapture = 1'b0;
            w_timerLoad   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc        <= '0;
            r_opcode    <= '0;
            r_qubit1    <= '0;
            r_qubit2    <= '0;
            r_measData  <= '0;
            r_gateCount <= '0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_pc        <= '0;
                r_gateCount <= '0;
            end
            if (r_state == ST_FETCH) begin
                r_opcode <= w_fetchOp;
                r_qubit1 <= instrQubit1(instr);
                r_qubit2 <= instrQubit2(instr);
            end
            if (w_accept && (r_gateCount != COUNT_MAX)) begin
                r_gateCount <= r_gateCount + (PC_W+1)'(1);
            end
            if (w_advance) begin
                r_pc <= w_pcLast ? '0 : r_pc + PC_W'(1);
            end
            if (w_measCapture) begin
                r_measData <= core.meas_result;
            end
        end
    end

    assign pc               = r_pc;
    assign core.issue_valid = w_issueValid;
    assign core.opcode      = r_opcode;
    assign core.qubit1      = r_qubit1;
    assign core.qubit2      = r_qubit2;
    assign meas_valid       = w_measValid;
    assign meas_data        = r_measData;
    assign busy             = w_busy;
    assign done             = w_done;
    assign gate_count       = r_gateCount;

endmodule

// File: tb/tb_qpu_sequencer.sv
// Directed self-checking bench for qpu_sequencer with a behavioural ROM and
// a scripted core_ready/meas_result stand-in for the quantum core.
module tb_qpu_sequencer;
    import qpu_sequencer_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] pc;
    logic [6:0] instr;
    logic       meas_valid;
    logic [1:0] meas_data;
    logic       busy;
    logic       done;
    logic [4:0] gate_count;

    logic [6:0] rom [16];

    int testsRun;
    int testsFailed;
    int timedOut;
    int issuePcs[$];
    int doneCycles[$];
    int measCycles[$];
    int measVals[$];

    qpu_sequencer_if bus ();

    qpu_sequencer #(
        .PC_W   (4),
        .SETTLE (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .pc         (pc),
        .instr      (instr),
        .core       (bus.master),
        .meas_valid (meas_valid),
        .meas_data  (meas_data),
        .busy       (busy),
        .done       (done),
        .gate_count (gate_count)
    );

    assign instr = rom[pc];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic loadRom(input logic [6:0] fill);
        for (int i = 0; i < 16; i++) rom[i] = fill;
    endtask

    // Launches a run and records every accepted gate, done and meas strobe by cycle number.
    task automatic runProgram(input int budget);
        int tail;
        issuePcs.delete();
        doneCycles.delete();
        measCycles.delete();
        measVals.delete();
        timedOut = 1;
        tail = -1;
        start = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            step();
            start = 1'b0;
            if (bus.issue_valid && bus.core_ready) issuePcs.push_back(int'(pc));
            if (done) doneCycles.push_back(k);
            if (meas_valid) begin
                measCycles.push_back(k);
                measVals.push_back(int'(meas_data));
            end
            if (!busy && tail < 0) tail = 2;
            else if (tail > 0) tail--;
            if (tail == 0) begin
                timedOut = 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) step();
        testsRun++;
        if ({pc, bus.issue_valid, bus.opcode, bus.qubit1, bus.qubit2, meas_valid, meas_data, done, busy, gate_count} !== 22'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset.outputs: got pc=%0d iv=%b op=%b q1=%b q2=%b mv=%b md=%b done=%b busy=%b gc=%0d, expected all zero",
                     pc, bus.issue_valid, bus.opcode, bus.qubit1, bus.qubit2, meas_valid, meas_data, done, busy, gate_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) step();
        testsRun++;
        if ({busy, done, bus.issue_valid} !== 3'b000) begin
            testsFailed++;
            $display("[TB] FAIL reset.idle_after_release: got busy/done/iv=%b expected 000", {busy, done, bus.issue_valid});
        end
    endtask

    task automatic test_three_gates;
        loadRom({OP_HALT, 4'b0000});
        rom[0] = {3'b001, 2'b00, 2'b01};
        rom[1] = {3'b010, 2'b01, 2'b10};
        rom[2] = {3'b011, 2'b10, 2'b11};
        bus.core_ready = 1'b1;
        runProgram(40);
        testsRun++;
        if (timedOut != 0) begin testsFailed++; $display("[TB] FAIL three_gates.timeout: got running expected idle within 40 cycles"); end
        testsRun++;
        if (issuePcs.size() != 3) begin testsFailed++; $display("[TB] FAIL three_gates.issue_count: got %0d expected 3", issuePcs.size()); end
        for (int i = 0; i < 3; i++) begin
            int got;
            got = (i < issuePcs.size()) ? issuePcs[i] : -1;
            testsRun++;
            if (got != i) begin testsFailed++; $display("[TB] FAIL three_gates.issue_pc[%0d]: got %0d expected %0d", i, got, i); end
        end
        testsRun++;
        if (doneCycles.size() != 1 || doneCycles[0] != 8) begin
            testsFailed++;
            $display("[TB] FAIL three_gates.done: got %0d pulses first at %0d expected 1 pulse at cycle 8",
                     doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1);
        end
        testsRun++;
        if (gate_count !== 5'd3) begin testsFailed++; $display("[TB] FAIL three_gates.gate_count: got %0d expected 3", gate_count); end
        testsRun++;
        if (pc !== 4'd3) begin testsFailed++; $display("[TB] FAIL three_gates.pc_held: got %0d expected 3", pc); end
    endtask

    task automatic test_stall;
        loadRom({OP_HALT, 4'b0000});
        rom[0] = {3'b010, 2'b11, 2'b01};
        bus.core_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            testsRun++;
            if ({bus.issue_valid, bus.opcode, bus.qubit1, bus.qubit2, pc} !== {1'b1, 3'b010, 2'b11, 2'b01, 4'd0}) begin
                testsFailed++;
                $display("[TB] FAIL stall.hold[%0d]: got iv=%b op=%b q1=%b q2=%b pc=%0d expected iv=1 op=010 q1=11 q2=01 pc=0",
                         i, bus.issue_valid, bus.opcode, bus.qubit1, bus.qubit2, pc);
            end
            start = (i == 1);
            if (i == 4) bus.core_ready = 1'b1;
        end
        step();
        testsRun++;
        if ({pc, bus.issue_valid, gate_count} !== {4'd1, 1'b0, 5'd1}) begin
            testsFailed++;
            $display("[TB] FAIL stall.advance: got pc=%0d iv=%b gc=%0d expected pc=1 iv=0 gc=1", pc, bus.issue_valid, gate_count);
        end
        step();
        testsRun++;
        if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall.done: got %b expected 1", done); end
        step();
    endtask

    task automatic test_meas;
        loadRom({OP_HALT, 4'b0000});
        rom[0] = {3'b000, 2'b01, 2'b00};
        rom[1] = {OP_MEAS, 2'b00, 2'b01};
        rom[2] = {3'b101, 2'b10, 2'b01};
        bus.core_ready  = 1'b1;
        bus.meas_result = 2'b10;
        runProgram(40);
        testsRun++;
        if (timedOut != 0) begin testsFailed++; $display("[TB] FAIL meas.timeout: got running expected idle within 40 cycles"); end
        testsRun++;
        if (measCycles.size() != 1 || measCycles[0] != 6) begin
            testsFailed++;
            $display("[TB] FAIL meas.valid_cycle: got %0d strobes first at %0d expected 1 strobe at cycle 6",
                     measCycles.size(), (measCycles.size() > 0) ? measCycles[0] : -1);
        end
        testsRun++;
        if (measVals.size() != 1 || measVals[0] != 2) begin
            testsFailed++;
            $display("[TB] FAIL meas.data_at_strobe: got %0d expected 2", (measVals.size() > 0) ? measVals[0] : -1);
        end
        testsRun++;
        if (issuePcs.size() != 2 || issuePcs[0] != 0 || issuePcs[1] != 2) begin
            testsFailed++;
            $display("[TB] FAIL meas.issue_pcs: got %0d issues expected exactly pcs 0 and 2", issuePcs.size());
        end
        testsRun++;
        if (doneCycles.size() != 1 || doneCycles[0] != 10) begin
            testsFailed++;
            $display("[TB] FAIL meas.done: got %0d pulses first at %0d expected 1 pulse at cycle 10",
                     doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1);
        end
        testsRun++;
        if ({gate_count, meas_data} !== {5'd2, 2'b10}) begin
            testsFailed++;
            $display("[TB] FAIL meas.final: got gc=%0d md=%b expected gc=2 md=10", gate_count, meas_data);
        end
    endtask

    task automatic test_wrap;
        for (int i = 0; i < 16; i++) rom[i] = {3'(i % 6), 2'(i), 2'(i >> 2)};
        bus.core_ready = 1'b1;
        runProgram(60);
        testsRun++;
        if (timedOut != 0) begin testsFailed++; $display("[TB] FAIL wrap.timeout: got running expected idle within 60 cycles"); end
        testsRun++;
        if (issuePcs.size() != 16 || issuePcs[15] != 15) begin
            testsFailed++;
            $display("[TB] FAIL wrap.issues: got %0d issues expected 16 ending at pc 15", issuePcs.size());
        end
        testsRun++;
        if (doneCycles.size() != 1 || doneCycles[0] != 33) begin
            testsFailed++;
            $display("[TB] FAIL wrap.done: got %0d pulses first at %0d expected 1 pulse at cycle 33",
                     doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1);
        end
        testsRun++;
        if ({gate_count, pc, busy} !== {5'd16, 4'd0, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL wrap.final: got gc=%0d pc=%0d busy=%b expected gc=16 pc=0 busy=0", gate_count, pc, busy);
        end
    endtask

    task automatic test_abort;
        int found;
        int sawDone;
        loadRom({3'b001, 2'b10, 2'b00});
        bus.core_ready = 1'b1;
        found = 0;
        start = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step();
            start = 1'b0;
            if (pc == 4'd5 && bus.issue_valid) begin
                found = 1;
                break;
            end
        end
        testsRun++;
        if (found == 0) begin testsFailed++; $display("[TB] FAIL abort.reach_pc5: got no issue at pc 5 expected one within 40 cycles"); end
        testsRun++;
        if (gate_count !== 5'd5) begin testsFailed++; $display("[TB] FAIL abort.count_before: got %0d expected 5", gate_count); end
        abort = 1'b1;
        step();
        abort = 1'b0;
        testsRun++;
        if ({busy, bus.issue_valid, done, pc, gate_count} !== {1'b0, 1'b0, 1'b0, 4'd5, 5'd6}) begin
            testsFailed++;
            $display("[TB] FAIL abort.idle: got busy=%b iv=%b done=%b pc=%0d gc=%0d expected busy=0 iv=0 done=0 pc=5 gc=6",
                     busy, bus.issue_valid, done, pc, gate_count);
        end
        sawDone = 0;
        repeat (3) begin
            step();
            if (done || busy) sawDone = 1;
        end
        testsRun++;
        if (sawDone != 0) begin testsFailed++; $display("[TB] FAIL abort.stays_idle: got done/busy activity expected none"); end
        start = 1'b1;
        step();
        start = 1'b0;
        testsRun++;
        if ({busy, pc, gate_count} !== {1'b1, 4'd0, 5'd0}) begin
            testsFailed++;
            $display("[TB] FAIL abort.restart: got busy=%b pc=%0d gc=%0d expected busy=1 pc=0 gc=0", busy, pc, gate_count);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_settle;
        int sawActivity;
        loadRom({OP_HALT, 4'b0000});
        rom[0] = {3'b011, 2'b01, 2'b11};
        rom[1] = {OP_MEAS, 2'b11, 2'b10};
        bus.core_ready  = 1'b1;
        bus.meas_result = 2'b01;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        testsRun++;
        if ({busy, bus.opcode, pc, gate_count, meas_data} !== {1'b1, OP_MEAS, 4'd1, 5'd1, 2'b10}) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid.pre: got busy=%b op=%b pc=%0d gc=%0d md=%b expected busy=1 op=110 pc=1 gc=1 md=10",
                     busy, bus.opcode, pc, gate_count, meas_data);
        end
        #2;
        reset_n = 1'b0;
        #1;
        testsRun++;
        if ({pc, bus.issue_valid, bus.opcode, bus.qubit1, bus.qubit2, meas_valid, meas_data, done, busy, gate_count} !== 22'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_mid.outputs: got pc=%0d iv=%b op=%b q1=%b q2=%b mv=%b md=%b done=%b busy=%b gc=%0d, expected all zero",
                     pc, bus.issue_valid, bus.opcode, bus.qubit1, bus.qubit2, meas_valid, meas_data, done, busy, gate_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        sawActivity = 0;
        repeat (8) begin
            step();
            if (meas_valid || busy || done || bus.issue_valid) sawActivity = 1;
        end
        testsRun++;
        if (sawActivity != 0) begin testsFailed++; $display("[TB] FAIL reset_mid.no_pending: got output activity after release expected none"); end
    endtask

    initial begin
        testsRun        = 0;
        testsFailed     = 0;
        reset_n         = 1'b0;
        start           = 1'b0;
        abort           = 1'b0;
        bus.core_ready  = 1'b0;
        bus.meas_result = 2'b00;
        loadRom(7'd0);
        test_reset();
        test_three_gates();
        test_stall();
        test_meas();
        test_wrap();
        test_abort();
        test_reset_mid_settle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
